// File: rtl/tqvp_multi_edge_counter.sv
// Multi-channel edge counter peripheral for the TinyQV user-peripheral slot.
// Optional define TQVP_MEC_SYNC_EN adds a 2-flop synchroniser on every ui_in bit.
module tqvp_multi_edge_counter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       user_interrupt
);

  typedef enum logic [3:0] {
    A_CH_SEL = 4'h0,
    A_CMD    = 4'h1,
    A_CNT_LO = 4'h2,
    A_CNT_HI = 4'h3,
    A_CFG    = 4'h4,
    A_CMP_LO = 4'h5,
    A_CMP_HI = 4'h6,
    A_STATUS = 4'h7
  } reg_addr_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       ch_sel;
  logic [1:0]       sel;
  logic [7:0]       cnt_wsh;
  logic [7:0]       cmp_wsh;
  logic [7:0]       rd_sh;
  logic [7:0]       s_vec;
  logic [CNT_W-1:0] cnt_a [NUM_CH];
  logic [CNT_W-1:0] cmp_a [NUM_CH];
  logic [6:0]       cfg_a [NUM_CH];
  logic [NUM_CH-1:0] flags;
  logic [NUM_CH-1:0] irq_en;
  logic [CNT_W-1:0] sel_cnt;
  logic [CNT_W-1:0] sel_cmp;
  logic [6:0]       sel_cfg;
  logic [15:0]      cnt_ext;
  logic [15:0]      cmp_ext;

`ifdef TQVP_MEC_SYNC_EN
  logic [7:0] sync1;
  logic [7:0] sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ui_in;
      sync2 <= sync1;
    end
  end
  assign s_vec = sync2;
`else
  assign s_vec = ui_in;
`endif

  assign sel = (32'(ch_sel) >= NUM_CH) ? 2'(NUM_CH - 1) : ch_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cmp_q, cnt_d, stepped;
    logic [6:0]       cfg_q;
    logic             p_q, flag_q;
    logic             is_sel, s, hit, pin_chg, inc, clr, load, set_flag;
    logic [1:0]       step;
    logic [CNT_W+1:0] sum;

    assign is_sel  = data_write && (sel == 2'(i));
    assign s       = s_vec[cfg_q[4:2]];
    assign pin_chg = is_sel && (address == A_CFG) && (data_in[4:2] != cfg_q[4:2]);
    assign clr     = is_sel && (address == A_CMD) && data_in[0];
    assign inc     = is_sel && (address == A_CMD) && data_in[1] && !data_in[0];
    assign load    = is_sel && (address == A_CNT_HI);

    always_comb begin
      unique case (cfg_q[1:0])
        2'd1:    hit = s & ~p_q;
        2'd2:    hit = ~s & p_q;
        2'd3:    hit = s ^ p_q;
        default: hit = 1'b0;
      endcase
      if (pin_chg) hit = 1'b0;
    end

    assign step    = {1'b0, hit} + {1'b0, inc};
    assign sum     = (CNT_W+2)'(cnt_q) + (CNT_W+2)'(step);
    assign stepped = (cfg_q[5] && (sum > (CNT_W+2)'(CNT_MAX))) ? CNT_MAX : sum[CNT_W-1:0];

    // Register writes take priority over edges; only edge/increment steps can match.
    always_comb begin
      if (clr)       cnt_d = '0;
      else if (load) cnt_d = CNT_W'({data_in, cnt_wsh});
      else           cnt_d = stepped;
    end
    assign set_flag = !clr && !load && (step != 2'd0) && (stepped == cmp_q);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        cmp_q  <= '1;
        cfg_q  <= '0;
        p_q    <= 1'b0;
        flag_q <= 1'b0;
      end else begin
        // A pin change reloads the history from the new pin so no false edge follows.
        p_q   <= pin_chg ? s_vec[data_in[4:2]] : s;
        cnt_q <= cnt_d;
        if (set_flag)
          flag_q <= 1'b1;
        else if (data_write && (address == A_STATUS) && data_in[i])
          flag_q <= 1'b0;
        if (is_sel && (address == A_CFG))
          cfg_q <= data_in[6:0];
        if (is_sel && (address == A_CMP_HI))
          cmp_q <= CNT_W'({data_in, cmp_wsh});
      end
    end

    assign cnt_a[i]  = cnt_q;
    assign cmp_a[i]  = cmp_q;
    assign cfg_a[i]  = cfg_q;
    assign flags[i]  = flag_q;
    assign irq_en[i] = cfg_q[6];
  end

  always_comb begin
    sel_cnt = '0;
    sel_cmp = '0;
    sel_cfg = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel == 2'(i)) begin
        sel_cnt = cnt_a[i];
        sel_cmp = cmp_a[i];
        sel_cfg = cfg_a[i];
      end
    end
  end

  assign cnt_ext = 16'(sel_cnt);
  assign cmp_ext = 16'(sel_cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_sel  <= '0;
      cnt_wsh <= '0;
      cmp_wsh <= '0;
      rd_sh   <= '0;
    end else begin
      if (data_write) begin
        if (address == A_CH_SEL) ch_sel  <= data_in[1:0];
        if (address == A_CNT_LO) cnt_wsh <= data_in;
        if (address == A_CMP_LO) cmp_wsh <= data_in;
      end else if (address == A_CNT_LO) begin
        rd_sh <= cnt_ext[15:8];
      end else if (address == A_CMP_LO) begin
        rd_sh <= cmp_ext[15:8];
      end
    end
  end

  always_comb begin
    unique case (address)
      A_CH_SEL: data_out = {6'b0, ch_sel};
      A_CNT_LO: data_out = cnt_ext[7:0];
      A_CNT_HI: data_out = rd_sh;
      A_CFG:    data_out = {1'b0, sel_cfg};
      A_CMP_LO: data_out = cmp_ext[7:0];
      A_CMP_HI: data_out = rd_sh;
      A_STATUS: data_out = 8'(flags);
      default:  data_out = '0;
    endcase
  end

  assign uo_out         = 8'(flags);
  assign user_interrupt = |(flags & irq_en);

endmodule

// File: doc/tqvp_multi_edge_counter.md
# tqvp_multi_edge_counter

Multi-channel, parametrised edge counter peripheral for the TinyQV user-peripheral slot. Each of NUM_CH channels counts rising, falling or both edges on a selectable ui_in pin into a CNT_W-bit counter with wrap or saturate overflow. A per-channel compare register sets a sticky match flag that can raise the peripheral interrupt. Registers sit on the standard 4-bit address / 8-bit data peripheral bus.

## Interface
- NUM_CH, 2, number of channels (1..4)
- CNT_W, 16, counter and compare width (8..16)
- clk  in  1  peripheral clock
- rst_n  in  1  reset, asynchronous, active-low
- ui_in  in  8  input pins (edge sources)
- uo_out  out  8  [NUM_CH-1:0] = match flags; other bits 0
- address  in  4  register address
- data_write  in  1  write strobe, one cycle per write
- data_in  in  8  write data
- data_out  out  8  read data, combinational from address
- user_interrupt  out  1  OR over channels of (match flag & IRQ_EN)

## Operation
- Register map; SEL = channel selected by CH_SEL; unlisted addresses read 0, writes ignored:
  - 0x0 CH_SEL: [1:0] channel index; values >= NUM_CH select channel NUM_CH-1.
  - 0x1 CMD (write-only): bit0 clear SEL counter; bit1 increment SEL counter; bit0 wins if both set.
  - 0x2 CNT_LO: read returns SEL counter[7:0] and latches counter[CNT_W-1:8] into read shadow; write stores byte in write shadow.
  - 0x3 CNT_HI: read returns read shadow; write loads SEL counter = {data_in, write shadow} truncated to CNT_W.
  - 0x4 CFG: [1:0] mode (0 off, 1 rise, 2 fall, 3 both); [4:2] pin index; [5] SAT (1 saturate, 0 wrap); [6] IRQ_EN.
  - 0x5 CMP_LO / 0x6 CMP_HI: compare value, same shadow scheme as CNT (separate write shadow).
  - 0x7 STATUS: read [NUM_CH-1:0] match flags; write 1 clears the bit.
- Edge detect per channel: s = sampled ui_in[pin]; p = s registered every cycle regardless of mode; rise = s & ~p, fall = ~s & p.
- Count step = 1 on enabled edge; CMD increment adds 1; both same cycle add 2.
- Overflow: wrap mode modulo 2^CNT_W; SAT mode clamps at 2^CNT_W-1.
- Match flag sets when an edge or CMD increment leaves counter == CMP; CNT_HI load and CMD clear never set it. Flag stays set until cleared by STATUS write; set wins over clear in same cycle.
- CNT_HI load or CMD clear in same cycle as an edge: the write wins, edge dropped.
- CFG write changing pin index: no count that cycle; p reloaded from new pin next cycle.
- When CNT_W = 8, CNT_HI/CMP_HI read 0, writes to high byte discarded.

## Timing
- Reset (async assert): counters 0, CMP all ones, CFG 0 (mode off), CH_SEL 0, shadows 0, p 0, flags 0; uo_out = 0, user_interrupt = 0, data_out = 0 at address 0x0.
- Writes take effect at the clk edge with data_write high; readback next cycle.
- Without sync: pin change before edge N -> counter updated at edge N, visible on data_out after it.
- Match flag and user_interrupt assert the cycle after the counter update that matched.
- Reset mid-count drops all state; counting resumes only after mode rewritten.

## Configuration
- TQVP_MEC_SYNC_EN defined: s comes from a 2-flop synchroniser per ui_in bit; counting latency +2 cycles; synchroniser flops reset to 0.
- Undefined: s = ui_in[pin] directly (inputs already synchronous).

## Test plan
- Ch0 mode 1 pin 0, 5 pulses on ui_in[0] -> CNT_LO 0x05, CNT_HI 0x00; mode 2 + 3 pulses -> 0x08; mode 3 + 2 pulses -> 0x0C.
- Load 0xFFFE, SAT=0, 3 rising edges -> 0x0001; SAT=1, same -> 0xFFFF.
- CMP = 0x0003, IRQ_EN=1, 3 edges -> STATUS bit0, uo_out[0], user_interrupt =1; write STATUS 0x01 -> all 0.
- CMD increment coincident with edge -> +2; CNT_HI load 0x1234 coincident with edge -> 0x1234.
- Ch1 pin 5 counts while ch0 pin 0 idle; toggling ui_in[0] leaves ch1 unchanged; pin change on CFG causes no spurious count.
- Reset asserted mid-count -> all counters 0, outputs 0 immediately without clk.
